// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the 8051 interrupt controller.
// Optional two-level nesting by IP is enabled with the INT_PRIO_EN macro.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_LO = 2'd1,
    PUSH_HI = 2'd2,
    LOAD    = 2'd3
  } state_t;

  localparam int         IE_EA_BIT      = 7;
  localparam logic [7:0] VEC_BASE_DEF   = 8'h03;
  localparam logic [7:0] VEC_STRIDE_DEF = 8'h08;
  localparam logic       LVL_LO         = 1'b0;
  localparam logic       LVL_HI         = 1'b1;

  // Vector arithmetic deliberately wraps at 8 bits; callers zero-extend.
  function automatic logic [7:0] vec_addr(input logic [7:0] idx,
                                          input logic [7:0] base,
                                          input logic [7:0] stride);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and the peripherals / SFRs / PC datapath.
// master = interrupt controller, slave = surrounding core.
interface interrupt_controller_if #(
  parameter int N_SRC = 5
);
  logic [N_SRC-1:0] irq;
  logic [7:0]       ie;
  logic [N_SRC-1:0] ip;
  logic             insn_boundary;
  logic             reti;
  logic [15:0]      pc_in;
  logic             stack_wr;
  logic [7:0]       stack_data;
  logic             pc_load;
  logic [15:0]      pc_vec;
  logic [N_SRC-1:0] int_ack;
  logic [1:0]       in_service;
  logic             busy;

  modport master (
    input  irq, ie, ip, insn_boundary, reti, pc_in,
    output stack_wr, stack_data, pc_load, pc_vec, int_ack, in_service, busy
  );

  modport slave (
    output irq, ie, ip, insn_boundary, reti, pc_in,
    input  stack_wr, stack_data, pc_load, pc_vec, int_ack, in_service, busy
  );
endinterface

// File: rtl/interrupt_controller_arbiter.sv
// Combinational fixed-priority picker: lowest set request index wins.
module int_prio_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the top so the lowest requesting index is written last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IW'(i);
        valid_o    = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// 8051 interrupt scheduler: arbitration, PC push (PCL then PCH), vector load, in-service tracking.
// Define INT_PRIO_EN for two-level nesting by IP; otherwise IP is ignored and nothing nests.
module interrupt_controller
  import int_ctrl_pkg::*;
#(
  parameter int         N_SRC      = 5,
  parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [7:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input logic                    clk,
  input logic                    rst,
  interrupt_controller_if.master bus
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_SRC-1:0] oh_q, oh_d;
  logic             lvl_q, lvl_d;
  logic [15:0]      pc_q, pc_d;
  logic [1:0]       in_service_q, in_service_d;
  logic             stack_wr_q, stack_wr_d;
  logic [7:0]       stack_data_q, stack_data_d;
  logic             pc_load_q, pc_load_d;
  logic [15:0]      pc_vec_q, pc_vec_d;
  logic [N_SRC-1:0] int_ack_q, int_ack_d;
  logic             busy_q, busy_d;

  logic [N_SRC-1:0] eligible_s, hi_s, lo_s, hi_grant_s, lo_grant_s, cand_oh_s;
  logic [IW-1:0]    hi_idx_s, lo_idx_s, cand_idx_s;
  logic             hi_any_s, lo_any_s, cand_valid_s, cand_lvl_s, accept_s;
  logic             unused_s;

  assign eligible_s = bus.irq & bus.ie[N_SRC-1:0] & {N_SRC{bus.ie[IE_EA_BIT]}};
  assign unused_s   = ^{bus.ie, bus.ip};

`ifdef INT_PRIO_EN
  assign hi_s = eligible_s & bus.ip;
  assign lo_s = eligible_s & ~bus.ip;
`else
  assign hi_s = '0;
  assign lo_s = eligible_s;
`endif

  int_prio_arbiter #(.N(N_SRC), .IW(IW)) u_arb_hi (
    .req_i   (hi_s),
    .grant_o (hi_grant_s),
    .idx_o   (hi_idx_s),
    .valid_o (hi_any_s)
  );

  int_prio_arbiter #(.N(N_SRC), .IW(IW)) u_arb_lo (
    .req_i   (lo_s),
    .grant_o (lo_grant_s),
    .idx_o   (lo_idx_s),
    .valid_o (lo_any_s)
  );

  // Candidate selection: an active level masks itself and everything below it.
  always_comb begin
    cand_valid_s = 1'b0;
    cand_idx_s   = '0;
    cand_oh_s    = '0;
    cand_lvl_s   = LVL_LO;
    if (in_service_q[LVL_HI]) begin
      cand_valid_s = 1'b0;
    end else if (hi_any_s) begin
      cand_valid_s = 1'b1;
      cand_idx_s   = hi_idx_s;
      cand_oh_s    = hi_grant_s;
      cand_lvl_s   = LVL_HI;
    end else if (in_service_q[LVL_LO]) begin
      cand_valid_s = 1'b0;
    end else if (lo_any_s) begin
      cand_valid_s = 1'b1;
      cand_idx_s   = lo_idx_s;
      cand_oh_s    = lo_grant_s;
      cand_lvl_s   = LVL_LO;
    end else begin
      cand_valid_s = 1'b0;
    end
  end

  // A RETI in the same cycle blocks acceptance so one instruction runs after it.
  assign accept_s = (state_q == IDLE) && bus.insn_boundary && !bus.reti && cand_valid_s;

  // Sequencer next state and the per-state actions (registered below).
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    oh_d         = oh_q;
    lvl_d        = lvl_q;
    pc_d         = pc_q;
    stack_wr_d   = 1'b0;
    stack_data_d = stack_data_q;
    pc_load_d    = 1'b0;
    pc_vec_d     = pc_vec_q;
    int_ack_d    = '0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = PUSH_LO;
          idx_d   = cand_idx_s;
          oh_d    = cand_oh_s;
          lvl_d   = cand_lvl_s;
          pc_d    = bus.pc_in;
        end else begin
          state_d = IDLE;
        end
      end
      PUSH_LO: begin
        state_d      = PUSH_HI;
        stack_wr_d   = 1'b1;
        stack_data_d = pc_q[7:0];
      end
      PUSH_HI: begin
        state_d      = LOAD;
        stack_wr_d   = 1'b1;
        stack_data_d = pc_q[15:8];
      end
      LOAD: begin
        state_d   = IDLE;
        pc_load_d = 1'b1;
        pc_vec_d  = {8'h00, vec_addr(8'(idx_q), VEC_BASE, VEC_STRIDE)};
        int_ack_d = oh_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // In-service levels: RETI retires the highest active level, LOAD marks the new one.
  always_comb begin
    in_service_d = in_service_q;
    if (bus.reti) begin
      if (in_service_q[LVL_HI]) begin
        in_service_d[LVL_HI] = 1'b0;
      end else begin
        in_service_d[LVL_LO] = 1'b0;
      end
    end else begin
      in_service_d = in_service_q;
    end
    if (state_q == LOAD) begin
      in_service_d[lvl_q] = 1'b1;
    end else begin
      in_service_d = in_service_d;
    end
`ifndef INT_PRIO_EN
    in_service_d[LVL_HI] = 1'b0;
`endif
  end

  // State, latched request context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      oh_q         <= '0;
      lvl_q        <= LVL_LO;
      pc_q         <= 16'h0000;
      in_service_q <= 2'b00;
      stack_wr_q   <= 1'b0;
      stack_data_q <= 8'h00;
      pc_load_q    <= 1'b0;
      pc_vec_q     <= 16'h0000;
      int_ack_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      oh_q         <= oh_d;
      lvl_q        <= lvl_d;
      pc_q         <= pc_d;
      in_service_q <= in_service_d;
      stack_wr_q   <= stack_wr_d;
      stack_data_q <= stack_data_d;
      pc_load_q    <= pc_load_d;
      pc_vec_q     <= pc_vec_d;
      int_ack_q    <= int_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.stack_wr   = stack_wr_q;
  assign bus.stack_data = stack_data_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.pc_vec     = pc_vec_q;
  assign bus.int_ack    = int_ack_q;
  assign bus.in_service = in_service_q;
  assign bus.busy       = busy_q;

endmodule
